// File: rtl/dual_port_ram_init_if.sv
// Bus bundle for dual_port_ram_init: two independent access ports plus status.
// The master drives the accesses; the slave (the RAM) returns read data, valids, ready and collision.
interface dual_port_ram_init_if #(
    parameter int WORD_SIZE  = 16,
    parameter int ADDR_WIDTH = 6
);
    logic                  en_a;
    logic                  en_b;
    logic                  we_a;
    logic                  we_b;
    logic [ADDR_WIDTH-1:0] addr_a;
    logic [ADDR_WIDTH-1:0] addr_b;
    logic [WORD_SIZE-1:0]  data_a;
    logic [WORD_SIZE-1:0]  data_b;
    logic [WORD_SIZE-1:0]  q_a;
    logic [WORD_SIZE-1:0]  q_b;
    logic                  valid_a;
    logic                  valid_b;
    logic                  ready;
    logic                  collision;

    modport master (
        output en_a, en_b, we_a, we_b, addr_a, addr_b, data_a, data_b,
        input  q_a, q_b, valid_a, valid_b, ready, collision
    );

    modport slave (
        input  en_a, en_b, we_a, we_b, addr_a, addr_b, data_a, data_b,
        output q_a, q_b, valid_a, valid_b, ready, collision
    );
endinterface

// File: rtl/dual_port_ram_init.sv
// True dual-port RAM that sweeps INIT_VALUE into every word after reset before accepting accesses.
// Optional same-address conflict flag is built only when DPRAM_COLLISION_FLAG_EN is defined.
module dual_port_ram_init #(
    parameter int                   WORD_SIZE  = 16,
    parameter int                   ADDR_WIDTH = 6,
    parameter logic [WORD_SIZE-1:0] INIT_VALUE = '0,
    parameter int                   OUT_REG    = 0
) (
    input logic                clk,
    input logic                reset,
    dual_port_ram_init_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] sweep_cnt;
    logic                  ready_r;
    logic [WORD_SIZE-1:0]  mem [DEPTH];

    logic                  acc_a_p0;
    logic                  acc_b_p0;
    logic                  wr_a_p0;
    logic                  wr_b_p0;

    logic [WORD_SIZE-1:0]  q_a_p1;
    logic [WORD_SIZE-1:0]  q_b_p1;
    logic                  vld_a_p1;
    logic                  vld_b_p1;

    // Stage p0: access qualification (user ports are dead until the sweep is done)
    assign acc_a_p0 = (state == RUN) && !reset && bus.en_a;
    assign acc_b_p0 = (state == RUN) && !reset && bus.en_b;
    assign wr_a_p0  = acc_a_p0 && bus.we_a;
    assign wr_b_p0  = acc_b_p0 && bus.we_b;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= CLEAR;
            sweep_cnt <= '0;
            ready_r   <= 1'b0;
        end else if (state == CLEAR) begin
            sweep_cnt <= sweep_cnt + 1'b1;
            if (sweep_cnt == '1) begin
                state   <= RUN;
                ready_r <= 1'b1;
            end
        end
    end

    // Port B is written first so port A wins a same-address double write
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state == CLEAR) begin
                mem[sweep_cnt] <= INIT_VALUE;
            end else begin
                if (wr_b_p0) mem[bus.addr_b] <= bus.data_b;
                if (wr_a_p0) mem[bus.addr_a] <= bus.data_a;
            end
        end
    end

    // Stage p1: array reads see pre-write contents; writes return their own data
    always_ff @(posedge clk) begin
        if (reset) begin
            q_a_p1   <= '0;
            q_b_p1   <= '0;
            vld_a_p1 <= 1'b0;
            vld_b_p1 <= 1'b0;
        end else begin
            vld_a_p1 <= acc_a_p0;
            vld_b_p1 <= acc_b_p0;
            if (acc_a_p0) q_a_p1 <= bus.we_a ? bus.data_a : mem[bus.addr_a];
            if (acc_b_p0) q_b_p1 <= bus.we_b ? bus.data_b : mem[bus.addr_b];
        end
    end

    // Stage p2: optional output register, q holds between valid pulses
    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [WORD_SIZE-1:0] q_a_p2;
            logic [WORD_SIZE-1:0] q_b_p2;
            logic                 vld_a_p2;
            logic                 vld_b_p2;

            always_ff @(posedge clk) begin
                if (reset) begin
                    q_a_p2   <= '0;
                    q_b_p2   <= '0;
                    vld_a_p2 <= 1'b0;
                    vld_b_p2 <= 1'b0;
                end else begin
                    vld_a_p2 <= vld_a_p1;
                    vld_b_p2 <= vld_b_p1;
                    if (vld_a_p1) q_a_p2 <= q_a_p1;
                    if (vld_b_p1) q_b_p2 <= q_b_p1;
                end
            end

            assign bus.q_a     = q_a_p2;
            assign bus.q_b     = q_b_p2;
            assign bus.valid_a = vld_a_p2;
            assign bus.valid_b = vld_b_p2;
        end else begin : g_no_out_reg
            assign bus.q_a     = q_a_p1;
            assign bus.q_b     = q_b_p1;
            assign bus.valid_a = vld_a_p1;
            assign bus.valid_b = vld_b_p1;
        end
    endgenerate

    assign bus.ready = ready_r;

`ifdef DPRAM_COLLISION_FLAG_EN
    logic col_p0;
    logic col_p1;

    assign col_p0 = acc_a_p0 && acc_b_p0 && (bus.addr_a == bus.addr_b) && (bus.we_a || bus.we_b);

    always_ff @(posedge clk) begin
        if (reset) col_p1 <= 1'b0;
        else       col_p1 <= col_p0;
    end

    // Flag follows the same pipeline depth as the read data
    generate
        if (OUT_REG != 0) begin : g_col_reg
            logic col_p2;
            always_ff @(posedge clk) begin
                if (reset) col_p2 <= 1'b0;
                else       col_p2 <= col_p1;
            end
            assign bus.collision = col_p2;
        end else begin : g_col_noreg
            assign bus.collision = col_p1;
        end
    endgenerate
`else
    assign bus.collision = 1'b0;
`endif

endmodule

// File: tb/tb_dual_port_ram_init.sv
// Scoreboarded bench for dual_port_ram_init: stimulus pushes expected read data, a monitor pops on valid.
// The reference memory is a plain array updated with the port rules (reads see old data, A wins on writes).
module tb_dual_port_ram_init;
    localparam int              WS      = 16;
    localparam int              AW      = 6;
    localparam int              DEPTH   = 1 << AW;
    localparam logic [WS-1:0]   INIT_V  = 16'h5A3C;
    localparam int              OUT_REG = 0;
`ifdef DPRAM_COLLISION_FLAG_EN
    localparam bit              COL_EN  = 1'b1;
`else
    localparam bit              COL_EN  = 1'b0;
`endif

    typedef struct {
        logic [WS-1:0] q;
        logic          col;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    exp_t          qa[$];
    logic [WS-1:0] qb[$];
    logic [WS-1:0] model_mem [DEPTH];
    exp_t          mon_e;
    logic [WS-1:0] mon_b;

    always #5 clk = ~clk;

    dual_port_ram_init_if #(.WORD_SIZE(WS), .ADDR_WIDTH(AW)) bus ();

    dual_port_ram_init #(
        .WORD_SIZE (WS),
        .ADDR_WIDTH(AW),
        .INIT_VALUE(INIT_V),
        .OUT_REG   (OUT_REG)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares every presented output against the oldest expectation
    always begin
        @(posedge clk);
        #1;
        if (bus.valid_a) begin
            if (qa.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid_a: got q_a=%0h, expected no valid", bus.q_a);
            end else begin
                mon_e = qa.pop_front();
                check("q_a", bus.q_a, mon_e.q);
                check("collision", bus.collision, mon_e.col);
            end
        end else begin
            check("collision_idle", bus.collision, 0);
        end
        if (bus.valid_b) begin
            if (qb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid_b: got q_b=%0h, expected no valid", bus.q_b);
            end else begin
                mon_b = qb.pop_front();
                check("q_b", bus.q_b, mon_b);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time exceeded");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    task automatic quiet();
        bus.en_a = 1'b0;
        bus.en_b = 1'b0;
        bus.we_a = 1'b0;
        bus.we_b = 1'b0;
    endtask

    task automatic junk();
        bus.en_a   = 1'b1;
        bus.en_b   = 1'b1;
        bus.we_a   = 1'($urandom_range(1, 0));
        bus.we_b   = 1'($urandom_range(1, 0));
        bus.addr_a = AW'($urandom);
        bus.addr_b = AW'($urandom);
        bus.data_a = WS'($urandom);
        bus.data_b = WS'($urandom);
    endtask

    task automatic access(input logic ea, input logic wa, input logic [AW-1:0] aa, input logic [WS-1:0] da,
                          input logic eb, input logic wb, input logic [AW-1:0] ab, input logic [WS-1:0] db);
        exp_t          e;
        logic [WS-1:0] ra;
        logic [WS-1:0] rb;
        ra = model_mem[aa];
        rb = model_mem[ab];
        bus.en_a = ea; bus.we_a = wa; bus.addr_a = aa; bus.data_a = da;
        bus.en_b = eb; bus.we_b = wb; bus.addr_b = ab; bus.data_b = db;
        if (ea) begin
            e.q   = wa ? da : ra;
            e.col = COL_EN && eb && (aa == ab) && (wa || wb);
            qa.push_back(e);
        end
        if (eb) qb.push_back(wb ? db : rb);
        if (eb && wb) model_mem[ab] = db;
        if (ea && wa) model_mem[aa] = da;
        @(negedge clk);
    endtask

    task automatic drain();
        int n;
        quiet();
        n = 0;
        while ((qa.size() != 0 || qb.size() != 0) && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (qa.size() != 0 || qb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d/%0d pending, expected 0/0", qa.size(), qb.size());
            qa.delete();
            qb.delete();
        end
        @(negedge clk);
    endtask

    task automatic pulse_reset();
        junk();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < DEPTH; i++) model_mem[i] = INIT_V;
        check("rst_q_a", bus.q_a, 0);
        check("rst_q_b", bus.q_b, 0);
        check("rst_valid", {bus.valid_a, bus.valid_b}, 0);
        check("rst_ready", bus.ready, 0);
        check("rst_collision", bus.collision, 0);
    endtask

    task automatic reset_and_sweep(input int abort_at);
        int   lowcnt;
        logic bad;
        pulse_reset();
        for (int i = 0; i < abort_at; i++) begin
            junk();
            @(negedge clk);
        end
        if (abort_at > 0) pulse_reset();
        lowcnt = 0;
        bad = 1'b0;
        while (!bus.ready && lowcnt < 200) begin
            lowcnt++;
            if (bus.q_a !== '0 || bus.q_b !== '0) bad = 1'b1;
            junk();
            @(negedge clk);
        end
        quiet();
        check("sweep_len", lowcnt, 64);
        check("sweep_q_zero", bad, 0);
    endtask

    task automatic read_all();
        for (int i = 0; i < DEPTH; i++)
            access(1'b1, 1'b0, AW'(i), '0, 1'b1, 1'b0, AW'(DEPTH - 1 - i), '0);
        drain();
    endtask

    initial begin
        quiet();
        bus.addr_a = '0; bus.addr_b = '0; bus.data_a = '0; bus.data_b = '0;
        @(negedge clk);

        reset_and_sweep(0);
        read_all();

        // Write then read on the other port, with a latency check
        access(1'b1, 1'b1, AW'(5), 16'hBEEF, 1'b0, 1'b0, '0, '0);
        access(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, AW'(5), '0);
        quiet();
        if (OUT_REG != 0) @(negedge clk);
        check("lat_valid_b", bus.valid_b, 1);
        check("lat_q_b", bus.q_b, 16'hBEEF);
        drain();

        // Read-before-write across ports
        access(1'b1, 1'b1, AW'(9), 16'h1111, 1'b0, 1'b0, '0, '0);
        access(1'b1, 1'b1, AW'(9), 16'h2222, 1'b1, 1'b0, AW'(9), '0);
        access(1'b1, 1'b0, AW'(9), '0, 1'b1, 1'b0, AW'(9), '0);
        drain();

        // Double write to one address
        access(1'b1, 1'b1, AW'(3), 16'hAAAA, 1'b1, 1'b1, AW'(3), 16'h5555);
        access(1'b1, 1'b0, AW'(3), '0, 1'b1, 1'b0, AW'(3), '0);
        drain();

        // Random traffic on a narrow address window to force conflicts
        for (int i = 0; i < 400; i++)
            access(1'($urandom_range(3, 0) != 0), 1'($urandom_range(1, 0)), AW'($urandom_range(15, 0)), WS'($urandom),
                   1'($urandom_range(3, 0) != 0), 1'($urandom_range(1, 0)), AW'($urandom_range(15, 0)), WS'($urandom));
        drain();

        // Hold behaviour with port A idle
        access(1'b1, 1'b1, AW'(20), 16'h1234, 1'b0, 1'b0, '0, '0);
        access(1'b1, 1'b0, AW'(20), '0, 1'b0, 1'b0, '0, '0);
        drain();
        for (int i = 0; i < 10; i++) begin
            check("hold_q_a", bus.q_a, 16'h1234);
            check("hold_valid_a", bus.valid_a, 0);
            @(negedge clk);
        end

        // Reset during a sweep restarts it from address 0
        reset_and_sweep(20);
        read_all();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
